// File: rtl/reg_read_unit.sv
// Dual-port register read unit with a per-register busy scoreboard and one-cycle registered read data.
// Optional writeback-to-read bypass is enabled by defining REG_READ_BYPASS_EN.
module reg_read_unit #(
  parameter int ADDR_W = 3,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREG*16-1:0]   rf_data,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [15:0]          rd_data_a,
  output logic [15:0]          rd_data_b,
  input  logic                 claim_en,
  input  logic [ADDR_W-1:0]    claim_addr,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [15:0]          wb_data,
  output logic [NREG-1:0]      busy_vec
);

  logic        hit_a, hit_b;
  logic        blk_a, blk_b;
  logic        accept;
  logic [15:0] src_a, src_b;

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
`ifdef REG_READ_BYPASS_EN
    hit_a = wb_we && (wb_addr == rd_addr_a);
    hit_b = wb_we && (wb_addr == rd_addr_b);
`endif
    // Readiness uses the scoreboard as it stands before this edge's claim/writeback.
    blk_a    = busy_vec[rd_addr_a] && !hit_a;
    blk_b    = busy_vec[rd_addr_b] && !hit_b;
    rd_ready = !(blk_a || blk_b);
    accept   = rd_req && rd_ready;
    src_a    = hit_a ? wb_data : rf_data[{rd_addr_a, 4'b0000} +: 16];
    src_b    = hit_b ? wb_data : rf_data[{rd_addr_b, 4'b0000} +: 16];
  end

  // A claim overrides a same-cycle writeback: the new write is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      for (int unsigned k = 0; k < NREG; k++) begin
        if (claim_en && (claim_addr == ADDR_W'(k)))
          busy_vec[k] <= 1'b1;
        else if (wb_we && (wb_addr == ADDR_W'(k)))
          busy_vec[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        rd_data_a <= src_a;
        rd_data_b <= src_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_read_unit.sv
// Scoreboard bench for reg_read_unit: a driver issues directed and random traffic, a monitor checks results.
module tb_reg_read_unit;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
`ifdef REG_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [NREG*16-1:0] rf_data;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr_a, rd_addr_b;
  logic               rd_ready, rd_valid;
  logic [15:0]        rd_data_a, rd_data_b;
  logic               claim_en;
  logic [ADDR_W-1:0]  claim_addr;
  logic               wb_we;
  logic [ADDR_W-1:0]  wb_addr;
  logic [15:0]        wb_data;
  logic [NREG-1:0]    busy_vec;

  reg_read_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rf_data(rf_data),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: register file contents and outstanding-write flags.
  logic [15:0] rf    [NREG];
  bit          mbusy [NREG];

  typedef struct {
    int unsigned tag;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  logic [15:0] last_a = '0, last_b = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rf_data = '0;
    for (int k = 0; k < NREG; k++) rf_data[16*k +: 16] = rf[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hit(input logic [ADDR_W-1:0] a);
    return BYP && wb_we && (wb_addr == a);
  endfunction

  function automatic bit blocked(input logic [ADDR_W-1:0] a);
    return mbusy[a] && !hit(a);
  endfunction

  function automatic logic [15:0] src(input logic [ADDR_W-1:0] a);
    return hit(a) ? wb_data : rf[a];
  endfunction

  task automatic idle();
    rd_req = 0; rd_addr_a = '0; rd_addr_b = '0;
    claim_en = 0; claim_addr = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    logic          exp_rdy;
    logic [NREG-1:0] bv;
    #1;
    exp_rdy = !(blocked(rd_addr_a) || blocked(rd_addr_b));
    chk("rd_ready", {31'b0, rd_ready}, {31'b0, exp_rdy});
    for (int k = 0; k < NREG; k++) bv[k] = mbusy[k];
    chk("busy_vec", {24'b0, busy_vec}, {24'b0, bv});
    if (rd_req && exp_rdy)
      q.push_back('{tag: cyc + 1, a: src(rd_addr_a), b: src(rd_addr_b)});
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NREG; k++) begin
      if (claim_en && claim_addr == ADDR_W'(k)) mbusy[k] = 1'b1;
      else if (wb_we && wb_addr == ADDR_W'(k)) mbusy[k] = 1'b0;
    end
    if (wb_we) rf[wb_addr] = wb_data;
  endtask

  task automatic rd(input int a, input int b);
    idle(); rd_req = 1; rd_addr_a = ADDR_W'(a); rd_addr_b = ADDR_W'(b);
  endtask

  // Monitor: every valid cycle must match the oldest expected result, tagged with its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("valid_cycle", cyc, mon_e.tag);
          chk("rd_data_a", {16'b0, rd_data_a}, {16'b0, mon_e.a});
          chk("rd_data_b", {16'b0, rd_data_b}, {16'b0, mon_e.b});
          last_a = mon_e.a;
          last_b = mon_e.b;
        end
      end else begin
        if (q.size() > 0 && q[0].tag <= cyc) begin
          chk("missing_valid", 32'd0, 32'd1);
          void'(q.pop_front());
        end
        chk("hold_a", {16'b0, rd_data_a}, {16'b0, last_a});
        chk("hold_b", {16'b0, rd_data_b}, {16'b0, last_b});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < NREG; k++) begin
      rf[k] = 16'($urandom);
      mbusy[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_busy", {24'b0, busy_vec}, 32'd0);
    rst_n = 1'b1;

    // Plain read
    rf[2] = 16'hBEEF; rf[5] = 16'h1234;
    rd(2, 5); cycle();
    idle(); cycle();
    idle(); cycle();

    // Same-address ports
    rf[1] = 16'h0F0F;
    rd(1, 1); cycle();
    idle(); cycle();

    // Stall behind a claim, released by writeback
    idle(); claim_en = 1; claim_addr = 3; cycle();
    rd(3, 0); cycle();
    rd(3, 0); wb_we = 1; wb_addr = 3; wb_data = 16'hA5A5; cycle();
    rd(3, 0); cycle();
    idle(); cycle();
    idle(); cycle();

    // Claim and writeback to the same register together
    idle(); claim_en = 1; claim_addr = 4; wb_we = 1; wb_addr = 4; wb_data = 16'h7777; cycle();
    chk("claim_wins", {31'b0, busy_vec[4]}, 32'd1);
    rd(4, 4); cycle();
    chk("r4_stalled", {31'b0, rd_ready}, 32'd0);
    idle(); wb_we = 1; wb_addr = 4; wb_data = 16'h4444; cycle();
    idle(); cycle();

    // Pipelined stream with one blocked cycle mid-stream
    idle(); claim_en = 1; claim_addr = 6; cycle();
    rd(0, 1); cycle();
    rd(2, 3); cycle();
    rd(6, 0); cycle();
    rd(4, 5); wb_we = 1; wb_addr = 6; wb_data = 16'h6666; cycle();
    rd(7, 1); cycle();
    rd(6, 6); cycle();
    idle(); cycle();
    idle(); cycle();

    // Asynchronous reset with a result pending and busy bits set
    idle(); claim_en = 1; claim_addr = 2; cycle();
    rd(0, 1); claim_en = 1; claim_addr = 3; cycle();
    chk("pre_reset_valid", {31'b0, rd_valid}, 32'd1);
    chk("pre_reset_busy", {24'b0, busy_vec}, 32'h0C);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, rd_valid}, 32'd0);
    chk("async_busy", {24'b0, busy_vec}, 32'd0);
    chk("async_data_a", {16'b0, rd_data_a}, 32'd0);
    chk("async_data_b", {16'b0, rd_data_b}, 32'd0);
    q.delete();
    last_a = '0; last_b = '0;
    for (int k = 0; k < NREG; k++) mbusy[k] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(); cycle();
    idle(); cycle();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rd_req    = ($urandom_range(0, 9) < 7);
      rd_addr_a = ADDR_W'($urandom);
      rd_addr_b = ADDR_W'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        claim_en   = 1;
        claim_addr = ADDR_W'($urandom);
      end
      if ($urandom_range(0, 9) < 5) begin
        wb_we   = 1;
        wb_addr = ADDR_W'($urandom);
        for (int t = 0; t < 4; t++)
          if (!mbusy[wb_addr]) wb_addr = ADDR_W'($urandom);
        wb_data = 16'($urandom);
      end
      cycle();
    end

    idle();
    repeat (3) cycle();
    chk("drain", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_read_unit.md
Name: reg_read_unit

Overview:
- Read-side companion to the 16-bit register file: two read ports with a request/valid handshake and one-cycle registered latency.
- A per-register busy scoreboard stalls reads of registers whose write is still in flight.
- Sits between decode (issues reads, claims destinations) and the register file (supplies flattened contents, receives writebacks).

Parameters:
- ADDR_W, 3, register address width.
- NREG, 2**ADDR_W, number of 16-bit registers, derived from ADDR_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rf_data  input  NREG*16  flattened register contents; Rk occupies bits [16k+15:16k]
- rd_req  input  1  read request for both ports
- rd_addr_a  input  ADDR_W  port A register index
- rd_addr_b  input  ADDR_W  port B register index
- rd_ready  output  1  request can be accepted this cycle (combinational)
- rd_valid  output  1  rd_data_a/b hold the result of the previous accepted request
- rd_data_a  output  16  port A read data (registered)
- rd_data_b  output  16  port B read data (registered)
- claim_en  input  1  mark claim_addr busy (a write to it is now in flight)
- claim_addr  input  ADDR_W  destination being claimed
- wb_we  input  1  writeback strobe (same strobe driven to the register file write enable)
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  16  writeback data
- busy_vec  output  NREG  current scoreboard, bit k = Rk busy

Behaviour:
- Reset: clk single clock domain; rst_n asynchronous, active-low.
  - On rst_n low: busy_vec=0, rd_valid=0, rd_data_a=0, rd_data_b=0, immediately and regardless of clk.
  - Any pending result is discarded.
- Blocking (port X in {a,b}): port X is blocked when busy[rd_addr_X]=1 and the register is not cleared by a bypass hit (see Optional Feature).
- rd_ready = 1 unless either port is blocked. rd_ready is independent of rd_req.
- Accept: rd_req=1 and rd_ready=1 at a rising edge.
  - Next cycle: rd_valid=1; rd_data_X = selected source for rd_addr_X.
  - Source is rf_data, or wb_data on a bypass hit.
- No accept: rd_valid=0 next cycle; rd_data_a/b hold their last values. rd_valid is a one-cycle pulse per accept.
- Back-to-back accepts give back-to-back valid cycles; throughput is 1 request/cycle.
- rd_addr_a==rd_addr_b is legal; both ports return the same value.
- Scoreboard update, per register k at each edge:
  - claim_en && claim_addr==k sets busy[k].
  - Otherwise wb_we && wb_addr==k clears busy[k].
  - Otherwise busy[k] holds.
- Scoreboard boundary cases:
  - Claim and writeback to the same register in the same cycle: claim wins, busy stays 1 (a new write is in flight).
  - Claim of an already-busy register: stays 1. Single outstanding write per register; counting is not required.
  - wb_we to a non-busy register: data flows to the register file; scoreboard unchanged.
- Ordering: the scoreboard updates after the readiness evaluation of the same cycle. A claim in cycle N does not block a read accepted in cycle N.
- No internal state machine beyond the busy bits and the valid/data pipeline register.

Optional Feature:
- Macro: REG_READ_BYPASS_EN.
- Defined:
  - A bypass hit on port X is wb_we=1 and wb_addr==rd_addr_X.
  - A hit unblocks port X even if busy, and the accepted read returns wb_data.
  - Zero-stall read-after-writeback.
- Undefined:
  - No bypass; a busy register blocks until the edge where wb clears it.
  - Read is accepted the following cycle at the earliest; data comes from rf_data, which by then holds the written value.
  - One extra stall cycle versus the defined build.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with rd_valid=1 and busy_vec=8'h0C -> outputs go 0 asynchronously. After release with rd_req=0 -> rd_valid stays 0.
- Plain read: rf_data R2=16'hBEEF, R5=16'h1234; rd_req=1, addr a=2, b=5, busy=0 -> rd_ready=1; next cycle rd_valid=1, rd_data_a=BEEF, rd_data_b=1234; following cycle rd_valid=0.
- Stall: claim R3; then rd_req with addr a=3 -> rd_ready=0 and no rd_valid. wb_we to R3 with 16'hA5A5:
  - Bypass build: accept in the wb cycle, rd_data_a=A5A5.
  - Non-bypass build: accept one cycle later, with rf_data R3=A5A5 supplied by the bench.
- Simultaneous claim and wb: claim_en and wb_we both to R4 in the same cycle -> busy_vec[4]=1 afterwards; a read of R4 still stalls.
- Pipelined stream: 4 consecutive accepted reads to different non-busy registers -> 4 consecutive rd_valid cycles with matching data; a mid-stream stall inserts exactly one rd_valid=0 cycle per blocked cycle.
- Same-address ports: addr a=b=1, R1=16'h0F0F -> both outputs 0F0F on the valid cycle.
